// File: rtl/hp_bar_overlay.sv
// Health-bar overlay stage: draws N_BARS HP bars with draining damage ghosts and low-HP blink,
// tracks a sticky win/lose verdict, and forwards timing/mouse signals with one cycle of latency.
module hp_bar_overlay #(
  parameter int          N_BARS      = 2,
  parameter int          HP_W        = 8,
  parameter int          BAR_X       = 810,
  parameter int          BAR_Y0      = 40,
  parameter int          BAR_H       = 16,
  parameter int          BAR_PITCH   = 30,
  parameter int          LOW_THR     = 32,
  parameter int          BLINK_SHIFT = 4,
  parameter int          DRAIN_STEP  = 2,
  parameter logic [11:0] COL_OWN     = 12'h3A0,
  parameter logic [11:0] COL_ENEMY   = 12'hF20,
  parameter logic [11:0] COL_GHOST   = 12'hFF0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BARS*HP_W-1:0]   hp_in,
  input  logic                     restart,
  input  logic                     hblnk,
  input  logic                     vblnk,
  input  logic                     hsync,
  input  logic                     vsync,
  input  logic [10:0]              hcount,
  input  logic [9:0]               vcount,
  input  logic [11:0]              rgb,
  input  logic [11:0]              xpos_m,
  input  logic [11:0]              ypos_m,
  input  logic                     select,
  output logic                     hblnk_out,
  output logic                     vblnk_out,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic [10:0]              hcount_out,
  output logic [9:0]               vcount_out,
  output logic [11:0]              rgb_out,
  output logic [11:0]              xpos_m_out,
  output logic [11:0]              ypos_m_out,
  output logic                     select_out,
  output logic [1:0]               game_end
);

  localparam int          FC_W    = BLINK_SHIFT + 1;
  localparam logic [11:0] BAR_X_W = 12'(BAR_X);

  logic [N_BARS-1:0][HP_W-1:0] hp_s;
  logic [N_BARS-1:0][HP_W-1:0] ghost_q, ghost_d;
  logic [FC_W-1:0]             frame_cnt_q, frame_cnt_d;
  logic [1:0]                  game_end_q, game_end_d;
  logic [11:0]                 rgb_q, rgb_d;
  logic                        hblnk_q, vblnk_q, hsync_q, vsync_q, select_q;
  logic [10:0]                 hcount_q;
  logic [9:0]                  vcount_q;
  logic [11:0]                 xpos_m_q, ypos_m_q;

  logic        tick_s;
  logic        blink_off_s;
  logic        enemies_dead_s;
  logic        in_row_s;
  logic        low_s;
  logic [11:0] hc_s, vc_s, row_top_s, hp_x_s, gh_x_s, pix_s;

  assign hp_s        = hp_in;
  assign tick_s      = (hcount == 11'd0) && (vcount == 10'd0);
  assign blink_off_s = frame_cnt_q[BLINK_SHIFT];
  assign hc_s        = {1'b0, hcount};
  assign vc_s        = {2'b00, vcount};

  // Frame counter and ghost drain/heal, advanced once per frame tick.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    ghost_d     = ghost_q;
    if (tick_s) begin
      frame_cnt_d = frame_cnt_q + FC_W'(1);
      for (int i = 0; i < N_BARS; i++) begin
        if (ghost_q[i] > hp_s[i]) begin
          if ((ghost_q[i] - hp_s[i]) > HP_W'(DRAIN_STEP)) begin
            ghost_d[i] = ghost_q[i] - HP_W'(DRAIN_STEP);
          end else begin
            ghost_d[i] = hp_s[i];
          end
        end else begin
          ghost_d[i] = hp_s[i];
        end
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
      ghost_d     = ghost_q;
    end
  end

  // Pixel compositing; bars are walked high-to-low so a lower index wins any overlap.
  always_comb begin
    pix_s     = rgb;
    row_top_s = 12'd0;
    hp_x_s    = 12'd0;
    gh_x_s    = 12'd0;
    in_row_s  = 1'b0;
    low_s     = 1'b0;
    for (int i = N_BARS - 1; i >= 0; i--) begin
      row_top_s = 12'(BAR_Y0 + i * BAR_PITCH);
      hp_x_s    = 12'(hp_s[i]);
      gh_x_s    = 12'(ghost_q[i]);
      in_row_s  = (vc_s >= row_top_s) && (vc_s < row_top_s + 12'(BAR_H));
      low_s     = (hp_x_s != 12'd0) && (hp_x_s < 12'(LOW_THR));
      if (in_row_s && (hc_s >= BAR_X_W) && (hc_s < BAR_X_W + hp_x_s) && !(low_s && blink_off_s)) begin
        pix_s = (i == 0) ? COL_OWN : COL_ENEMY;
      end else if (in_row_s && (hc_s >= BAR_X_W + hp_x_s) && (hc_s < BAR_X_W + gh_x_s)) begin
        pix_s = COL_GHOST;
      end else begin
        pix_s = pix_s;
      end
    end
    if (select) begin
      rgb_d = pix_s;
    end else begin
      rgb_d = rgb;
    end
  end

  // Sticky verdict; restart takes precedence over any same-cycle condition.
  always_comb begin
    enemies_dead_s = 1'b1;
    for (int i = 1; i < N_BARS; i++) begin
      if (hp_s[i] != {HP_W{1'b0}}) begin
        enemies_dead_s = 1'b0;
      end else begin
        enemies_dead_s = enemies_dead_s;
      end
    end
    game_end_d = game_end_q;
    if (restart) begin
      game_end_d = 2'd0;
    end else if (select && (game_end_q == 2'd0)) begin
      if (hp_s[0] == {HP_W{1'b0}}) begin
        game_end_d = 2'd2;
      end else if (enemies_dead_s) begin
        game_end_d = 2'd1;
      end else begin
        game_end_d = game_end_q;
      end
    end else begin
      game_end_d = game_end_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghost_q     <= '{default: {HP_W{1'b0}}};
      frame_cnt_q <= {FC_W{1'b0}};
      game_end_q  <= 2'd0;
      rgb_q       <= 12'd0;
      hblnk_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hcount_q    <= 11'd0;
      vcount_q    <= 10'd0;
      xpos_m_q    <= 12'd0;
      ypos_m_q    <= 12'd0;
      select_q    <= 1'b0;
    end else begin
      ghost_q     <= ghost_d;
      frame_cnt_q <= frame_cnt_d;
      game_end_q  <= game_end_d;
      rgb_q       <= rgb_d;
      hblnk_q     <= hblnk;
      vblnk_q     <= vblnk;
      hsync_q     <= hsync;
      vsync_q     <= vsync;
      hcount_q    <= hcount;
      vcount_q    <= vcount;
      xpos_m_q    <= xpos_m;
      ypos_m_q    <= ypos_m;
      select_q    <= select;
    end
  end

  assign hblnk_out  = hblnk_q;
  assign vblnk_out  = vblnk_q;
  assign hsync_out  = hsync_q;
  assign vsync_out  = vsync_q;
  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign rgb_out    = rgb_q;
  assign xpos_m_out = xpos_m_q;
  assign ypos_m_out = ypos_m_q;
  assign select_out = select_q;
  assign game_end   = game_end_q;

endmodule

// File: tb/tb_hp_bar_overlay.sv
// Scoreboard bench for hp_bar_overlay (3 bars): stimulus pushes model predictions, a monitor
// pops and compares one cycle later.
module tb_hp_bar_overlay;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] hp_in = 24'd0;
  logic        restart = 1'b0;
  logic        hblnk = 1'b0, vblnk = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic [10:0] hcount = 11'd5;
  logic [9:0]  vcount = 10'd5;
  logic [11:0] rgb = 12'd0, xpos_m = 12'd0, ypos_m = 12'd0;
  logic        select = 1'b0;
  logic        hblnk_out, vblnk_out, hsync_out, vsync_out, select_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic [11:0] rgb_out, xpos_m_out, ypos_m_out;
  logic [1:0]  game_end;

  hp_bar_overlay #(.N_BARS(3)) dut (
    .clk(clk), .rst_n(rst_n), .hp_in(hp_in), .restart(restart),
    .hblnk(hblnk), .vblnk(vblnk), .hsync(hsync), .vsync(vsync),
    .hcount(hcount), .vcount(vcount), .rgb(rgb), .xpos_m(xpos_m), .ypos_m(ypos_m),
    .select(select),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .rgb_out(rgb_out),
    .xpos_m_out(xpos_m_out), .ypos_m_out(ypos_m_out), .select_out(select_out),
    .game_end(game_end)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] rgb;
    logic [51:0] ctl;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state, in spec terms
  int   hp_m[3]    = '{0, 0, 0};
  int   ghost_m[3] = '{0, 0, 0};
  int   frame_m    = 0;
  int   ge_m       = 0;
  bit   sel_m      = 1'b0;

  function automatic logic [11:0] model_pix(int h, int v, logic [11:0] bg);
    int top;
    bit blink;
    if (!sel_m) return bg;
    blink = ((frame_m / 16) % 2) == 1;
    for (int i = 0; i < 3; i++) begin
      top = 40 + 30 * i;
      if (v >= top && v < top + 16) begin
        if (h >= 810 && h < 810 + hp_m[i] && !(hp_m[i] > 0 && hp_m[i] < 32 && blink))
          return (i == 0) ? 12'h3A0 : 12'hF20;
        if (h >= 810 + hp_m[i] && h < 810 + ghost_m[i]) return 12'hFF0;
        return bg;
      end
    end
    return bg;
  endfunction

  function automatic logic [51:0] out_ctl();
    return {hblnk_out, vblnk_out, hsync_out, vsync_out, hcount_out, vcount_out,
            xpos_m_out, ypos_m_out, select_out, game_end};
  endfunction

  task automatic step(input int h, input int v, input bit rs);
    exp_t e;
    int   ge_n;
    @(negedge clk);
    rgb     = 12'($urandom);
    xpos_m  = 12'($urandom);
    ypos_m  = 12'($urandom);
    hblnk   = 1'($urandom);
    vblnk   = 1'($urandom);
    hsync   = 1'($urandom);
    vsync   = 1'($urandom);
    hcount  = 11'(h);
    vcount  = 10'(v);
    restart = rs;
    select  = sel_m;
    hp_in   = {8'(hp_m[2]), 8'(hp_m[1]), 8'(hp_m[0])};
    ge_n = ge_m;
    if (rs) ge_n = 0;
    else if (sel_m && ge_m == 0) begin
      if (hp_m[0] == 0) ge_n = 2;
      else if (hp_m[1] == 0 && hp_m[2] == 0) ge_n = 1;
    end
    e.rgb = model_pix(h, v, rgb);
    e.ctl = {hblnk, vblnk, hsync, vsync, hcount, vcount, xpos_m, ypos_m, select, 2'(ge_n)};
    exp_q.push_back(e);
    ge_m = ge_n;
    if (h == 0 && v == 0) begin
      frame_m = (frame_m + 1) % 32;
      for (int i = 0; i < 3; i++) begin
        if (ghost_m[i] > hp_m[i]) ghost_m[i] = (ghost_m[i] - 2 > hp_m[i]) ? ghost_m[i] - 2 : hp_m[i];
        else ghost_m[i] = hp_m[i];
      end
    end
  endtask

  task automatic check_reset_zero(input string name);
    logic [63:0] act;
    act = {rgb_out, out_ctl()};
    n_cmp++;
    if (act != 64'd0) begin
      n_bad++;
      $display("FAIL %s: outputs=%h, want all zero", name, act);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) ghost_m[i] = 0;
    frame_m = 0;
    ge_m    = 0;
    select  = 1'b0;
    restart = 1'b0;
    hcount  = 11'd5;
    vcount  = 10'd5;
  endtask

  // Monitor: one pushed expectation is consumed per active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (rgb_out !== e.rgb) begin
          n_bad++;
          $display("FAIL pix h=%0d v=%0d: got rgb=%h, want %h", hcount_out, vcount_out, rgb_out, e.rgb);
        end
        n_cmp++;
        if (out_ctl() !== e.ctl) begin
          n_bad++;
          $display("FAIL ctl: got %h (game_end=%0d), want %h (game_end=%0d)",
                   out_ctl(), game_end, e.ctl, e.ctl[1:0]);
        end
      end
    end
  end

  initial begin
    #12;
    check_reset_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic geometry
    hp_m = '{100, 50, 40};
    sel_m = 1'b1;
    step(0, 0, 1'b0);
    for (int h = 805; h <= 865; h++) step(h, 45, 1'b0);
    for (int h = 805; h <= 915; h++) step(h, 75, 1'b0);
    for (int h = 805; h <= 855; h += 3) step(h, 100, 1'b0);
    step(815, 39, 1'b0);
    step(815, 56, 1'b0);
    step(815, 55, 1'b0);

    // Damage and ghost drain
    step(900, 45, 1'b0);
    hp_m[0] = 60;
    step(900, 45, 1'b0);
    for (int f = 0; f < 25; f++) begin
      step(0, 0, 1'b0);
      for (int h = 855; h <= 915; h += 5) step(h, 45, 1'b0);
      step(869, 45, 1'b0);
      step(870, 45, 1'b0);
    end

    // Low-HP blink
    hp_m[0] = 20;
    for (int f = 0; f < 70; f++) begin
      step(0, 0, 1'b0);
      step(815, 45, 1'b0);
      step(829, 45, 1'b0);
      step(830, 45, 1'b0);
    end

    // Verdicts
    hp_m[0] = 0;
    for (int k = 0; k < 3; k++) step(810, 45, 1'b0);
    hp_m[0] = 100;
    step(815, 45, 1'b0);
    step(815, 45, 1'b1);
    hp_m[1] = 0; hp_m[2] = 5;
    for (int k = 0; k < 3; k++) step(815, 100, 1'b0);
    hp_m[2] = 0;
    for (int k = 0; k < 3; k++) step(815, 100, 1'b0);
    hp_m[1] = 50; hp_m[2] = 40;
    for (int k = 0; k < 3; k++) step(815, 75, 1'b0);
    hp_m[1] = 0; hp_m[2] = 0;
    step(815, 75, 1'b1);
    step(815, 75, 1'b0);
    hp_m[1] = 50; hp_m[2] = 40;
    step(815, 75, 1'b1);
    step(815, 75, 1'b0);
    hp_m = '{0, 0, 0};
    for (int k = 0; k < 3; k++) step(815, 45, 1'b0);

    // select low: pass-through, no verdict
    sel_m = 1'b0;
    step(815, 45, 1'b1);
    for (int k = 0; k < 6; k++) step(810 + k * 20, 45 + (k % 3) * 30, 1'b0);

    // Randomised traffic around the bars
    sel_m = 1'b1;
    hp_m = '{100, 50, 40};
    for (int n = 0; n < 3000; n++) begin
      int h;
      int v;
      bit rs;
      if ($urandom_range(0, 99) == 0)
        for (int i = 0; i < 3; i++) hp_m[i] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255));
      if ($urandom_range(0, 299) == 0) sel_m = !sel_m;
      rs = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) begin
        h = 0;
        v = 0;
      end else begin
        h = $urandom_range(800, 1070);
        v = $urandom_range(35, 120);
      end
      step(h, v, rs);
    end

    // Mid-frame reset then recovery
    sel_m = 1'b1;
    hp_m = '{100, 50, 40};
    step(0, 0, 1'b0);
    hp_m[0] = 30;
    step(0, 0, 1'b0);
    step(850, 45, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_zero("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_zero("reset_hold");
    rst_n = 1'b1;
    hp_m = '{60, 50, 40};
    for (int h = 855; h <= 915; h += 5) step(h, 45, 1'b0);
    step(0, 0, 1'b0);
    for (int h = 855; h <= 915; h += 5) step(h, 45, 1'b0);
    for (int h = 855; h <= 915; h += 5) step(h, 75, 1'b0);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
